uart_rx: RTL and testbench

UART receiver that recovers serial frames from the `rx_in` line using the 16x oversampling tick from the baud generator. It sits between the pad-side serial input and the byte-level consumer, sharing `clock` and the `baud_rate` selection path with the transmitter. Each frame is validated for start-bit glitches, parity and stop-bit framing, then delivered as a parallel word with a one-cycle `data_valid` strobe.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_sampler.sv | 61 ++++++
 rtl/uart_rx.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receiver.
//   uart_rx_state_t : receiver FSM states
//   PARITY_*        : encodings of the 2-bit parity_type input
//   OVERSAMPLE      : baud_tick pulses per serial bit
//   MID_SAMPLE      : tick index of the nominal mid-bit point
//   maj3()          : 2-of-3 majority helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_ODD  = 2'b01;
  localparam logic [1:0] PARITY_EVEN = 2'b10;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 2-flop synchronizer for the serial line plus the bit
// decision used by the receiver FSM.
// Build option: UART_RX_MAJORITY_VOTE_EN selects a 2-of-3 vote over
// tick_cnt 6, 7 and 8; otherwise the synchronized line is used directly.
//   clock, reset_n : system clock, synchronous active-low reset
//   baud_tick_i    : 16x oversampling enable
//   tick_cnt_i     : receiver's position within the current bit
//   rx_i           : raw asynchronous serial line
//   rx_sync_o      : synchronized line
//   bit_sample_o   : bit value to use at the FSM's decision tick
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       baud_tick_i,
  input  logic [3:0] tick_cnt_i,
  input  logic       rx_i,
  output logic       rx_sync_o,
  output logic       bit_sample_o
);

  logic sync1_q;
  logic sync2_q;

  // Synchronizer flops reset to the idle (high) line level.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  assign rx_sync_o = sync2_q;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic s6_q;
  logic s7_q;

  // Capture the two earlier votes; the third is the live value at tick 8.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s6_q <= 1'b1;
      s7_q <= 1'b1;
    end else if (baud_tick_i) begin
      if (tick_cnt_i == 4'(MID_SAMPLE - 1)) s6_q <= sync2_q;
      if (tick_cnt_i == 4'(MID_SAMPLE))     s7_q <= sync2_q;
    end
  end

  assign bit_sample_o = maj3(s6_q, s7_q, sync2_q);
`else
  logic unused_tick;
  assign unused_tick  = ^{baud_tick_i, tick_cnt_i};
  assign bit_sample_o = sync2_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with 16x oversampling, start-glitch rejection,
// optional odd/even parity and stop-bit framing check.
// Build option: UART_RX_MAJORITY_VOTE_EN (3-sample majority per bit).
//   clock, reset_n : system clock, synchronous active-low reset
//   baud_tick      : 16x baud enable; all FSM state advances on it
//   rx_in          : asynchronous serial line, idles high
//   parity_type    : 00/11 none, 01 odd, 10 even (latched at start)
//   data_out       : last received payload, LSB first on the wire
//   data_valid     : one-cycle strobe per completed frame
//   parity_error   : parity mismatch in the last frame
//   framing_error  : stop bit sampled low in the last frame
//   rx_busy        : high from start detection until frame completion
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  input  logic [1:0]           parity_type,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 rx_busy
);

  // Decision points; the voted build starts DATA at 10 so its first data
  // decision lands on the same tick as the single-sample build.
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [3:0] START_PT  = 4'(MID_SAMPLE + 1);
  localparam logic [3:0] BIT_PT    = 4'(MID_SAMPLE + 1);
  localparam logic [3:0] DATA_INIT = 4'(MID_SAMPLE + 3);
`else
  localparam logic [3:0] START_PT  = 4'(MID_SAMPLE);
  localparam logic [3:0] BIT_PT    = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] DATA_INIT = 4'd0;
`endif

  uart_rx_state_t         state_q, state_d;
  logic [3:0]             tick_cnt_q, tick_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   armed_q, armed_d;
  logic [1:0]             par_mode_q, par_mode_d;
  logic                   par_err_q, par_err_d;
  logic [DATA_BITS-1:0]   data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   parity_error_q, parity_error_d;
  logic                   framing_error_q, framing_error_d;
  logic                   rx_busy_q, rx_busy_d;

  logic rx_sync;
  logic bit_sample;

  uart_rx_sampler u_sampler (
    .clock        (clock),
    .reset_n      (reset_n),
    .baud_tick_i  (baud_tick),
    .tick_cnt_i   (tick_cnt_q),
    .rx_i         (rx_in),
    .rx_sync_o    (rx_sync),
    .bit_sample_o (bit_sample)
  );

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      tick_cnt_q      <= 4'd0;
      bit_cnt_q       <= 3'd0;
      shift_q         <= '0;
      armed_q         <= 1'b0;
      par_mode_q      <= PARITY_NONE;
      par_err_q       <= 1'b0;
      data_out_q      <= '0;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      rx_busy_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      tick_cnt_q      <= tick_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      armed_q         <= armed_d;
      par_mode_q      <= par_mode_d;
      par_err_q       <= par_err_d;
      data_out_q      <= data_out_d;
      data_valid_q    <= data_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
      rx_busy_q       <= rx_busy_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d         = state_q;
    tick_cnt_d      = tick_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    armed_d         = armed_q;
    par_mode_d      = par_mode_q;
    par_err_d       = par_err_q;
    data_out_d      = data_out_q;
    data_valid_d    = 1'b0;
    parity_error_d  = parity_error_q;
    framing_error_d = framing_error_q;

    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          // A start edge only counts once the line has been seen high.
          if (rx_sync) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d    = START;
            tick_cnt_d = 4'd0;
            par_mode_d = parity_type;
            par_err_d  = 1'b0;
            armed_d    = 1'b0;
          end
        end
        START: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == START_PT) begin
            if (bit_sample) begin
              state_d    = IDLE;
              tick_cnt_d = 4'd0;
            end else begin
              state_d    = DATA;
              tick_cnt_d = DATA_INIT;
              bit_cnt_d  = 3'd0;
            end
          end
        end
        DATA: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == BIT_PT) begin
            shift_d   = {bit_sample, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
              state_d = ((par_mode_q == PARITY_ODD) || (par_mode_q == PARITY_EVEN))
                        ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == BIT_PT) begin
            par_err_d = ((^shift_q) ^ bit_sample) != (par_mode_q == PARITY_ODD);
            state_d   = STOP;
          end
        end
        STOP: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == BIT_PT) begin
            framing_error_d = ~bit_sample;
            parity_error_d  = par_err_q;
            data_out_d      = shift_q;
            data_valid_d    = 1'b1;
            state_d         = IDLE;
            tick_cnt_d      = 4'd0;
          end
        end
        default: begin
          state_d    = IDLE;
          tick_cnt_d = 4'd0;
        end
      endcase
    end

    rx_busy_d = (state_d != IDLE);
  end

  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign rx_busy       = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (default build).
// baud_tick pulses once every 3 clocks; frames are driven bit by bit in
// 16-tick periods and a monitor logs every data_valid strobe.
module tb_uart_rx;

  logic       clock;
  logic       reset_n;
  logic       baud_tick;
  logic       rx_in;
  logic [1:0] parity_type;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       rx_busy;

  int n_checks = 0;
  int n_errors = 0;

  int         vcnt = 0;
  int         wide_cnt = 0;
  logic       dv_prev = 1'b0;
  logic [7:0] rx_log[$];
  logic [1:0] div = 2'd0;

  uart_rx #(.DATA_BITS(8)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .baud_tick     (baud_tick),
    .rx_in         (rx_in),
    .parity_type   (parity_type),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .rx_busy       (rx_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Baud enable: one pulse every third clock.
  initial baud_tick = 1'b0;
  always @(posedge clock) begin
    div       <= (div == 2'd2) ? 2'd0 : div + 2'd1;
    baud_tick <= (div == 2'd2);
  end

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clock) begin
    if (data_valid) begin
      vcnt = vcnt + 1;
      rx_log.push_back(data_out);
      if (dv_prev) wide_cnt = wide_cnt + 1;
    end
    dv_prev = data_valid;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      while (baud_tick !== 1'b1) @(posedge clock);
    end
    @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par, input logic pbit,
                            input logic stop_bit, input bit chg_pt, input logic [1:0] new_pt);
    rx_in = 1'b0;
    wait_ticks(16);
    if (chg_pt) parity_type = new_pt;
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      wait_ticks(16);
    end
    if (has_par) begin
      rx_in = pbit;
      wait_ticks(16);
    end
    rx_in = stop_bit;
    wait_ticks(16);
    rx_in = 1'b1;
  endtask

  function automatic logic [7:0] log_at(input int idx);
    if (idx < rx_log.size()) return rx_log[idx];
    return 8'hxx;
  endfunction

  int base;

  initial begin
    reset_n     = 1'b0;
    rx_in       = 1'b1;
    parity_type = 2'b00;
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Reset state and idle line.
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_perr", 32'(parity_error), 32'h0);
    check("rst_ferr", 32'(framing_error), 32'h0);
    check("rst_busy", 32'(rx_busy), 32'h0);
    wait_ticks(64);
    check("idle_no_valid", 32'(vcnt), 32'd0);
    check("idle_busy", 32'(rx_busy), 32'h0);

    // 0xA5, no parity.
    base = vcnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    wait_ticks(4);
    check("a5_count", 32'(vcnt - base), 32'd1);
    check("a5_data", 32'(data_out), 32'hA5);
    check("a5_perr", 32'(parity_error), 32'h0);
    check("a5_ferr", 32'(framing_error), 32'h0);
    check("a5_busy", 32'(rx_busy), 32'h0);

    // 0x3C even parity: correct bit 0, then wrong bit 1.
    parity_type = 2'b10;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    wait_ticks(4);
    check("even_ok_data", 32'(data_out), 32'h3C);
    check("even_ok_perr", 32'(parity_error), 32'h0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
    wait_ticks(4);
    check("even_bad_data", 32'(data_out), 32'h3C);
    check("even_bad_perr", 32'(parity_error), 32'h1);
    check("even_bad_ferr", 32'(framing_error), 32'h0);

    // 0x3C odd parity with correct bit 1.
    parity_type = 2'b01;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
    wait_ticks(4);
    check("odd_ok_perr", 32'(parity_error), 32'h0);
    check("odd_ok_data", 32'(data_out), 32'h3C);

    // Parity mode changed mid-frame: frame still parsed without parity.
    parity_type = 2'b00;
    base = vcnt;
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
    wait_ticks(4);
    check("midpt_count", 32'(vcnt - base), 32'd1);
    check("midpt_data", 32'(data_out), 32'hC3);
    check("midpt_perr", 32'(parity_error), 32'h0);
    parity_type = 2'b00;
    wait_ticks(20);

    // 4-tick glitch on the idle line.
    base = vcnt;
    rx_in = 1'b0;
    wait_ticks(4);
    rx_in = 1'b1;
    check("glitch_busy_hi", 32'(rx_busy), 32'h1);
    wait_ticks(20);
    check("glitch_busy_lo", 32'(rx_busy), 32'h0);
    check("glitch_no_valid", 32'(vcnt - base), 32'd0);

    // 0x55 with stop low, 40-tick break, then 0x0F.
    base = vcnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    rx_in = 1'b0;
    check("brk_count", 32'(vcnt - base), 32'd1);
    check("brk_data", 32'(data_out), 32'h55);
    check("brk_ferr", 32'(framing_error), 32'h1);
    check("brk_perr", 32'(parity_error), 32'h0);
    wait_ticks(40);
    check("brk_busy", 32'(rx_busy), 32'h0);
    check("brk_no_start", 32'(vcnt - base), 32'd1);
    rx_in = 1'b1;
    wait_ticks(4);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    wait_ticks(4);
    check("after_brk_count", 32'(vcnt - base), 32'd2);
    check("after_brk_data", 32'(data_out), 32'h0F);
    check("after_brk_ferr", 32'(framing_error), 32'h0);

    // Back-to-back 0x81 and 0x7E, then reset during a third frame.
    base = vcnt;
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    check("b2b_count", 32'(vcnt - base), 32'd2);
    check("b2b_first", 32'(log_at(base)), 32'h81);
    check("b2b_second", 32'(log_at(base + 1)), 32'h7E);
    check("b2b_data_out", 32'(data_out), 32'h7E);
    rx_in = 1'b0;
    wait_ticks(16);
    rx_in = 1'b1;
    wait_ticks(16);
    rx_in = 1'b0;
    wait_ticks(16);
    check("mid_busy", 32'(rx_busy), 32'h1);
    reset_n = 1'b0;
    rx_in   = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("mrst_data_out", 32'(data_out), 32'h0);
    check("mrst_busy", 32'(rx_busy), 32'h0);
    check("mrst_perr", 32'(parity_error), 32'h0);
    check("mrst_ferr", 32'(framing_error), 32'h0);
    check("mrst_valid", 32'(data_valid), 32'h0);
    wait_ticks(200);
    check("mrst_no_valid", 32'(vcnt - base), 32'd2);

    check("valid_width", 32'(wide_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
